// File: rtl/multicycle_control_fsm_if.sv
// ============================================================================
// Module      : multicycle_control_fsm_if
// Description : Control bundle between the multi-cycle RV32I control unit and
//               the shared datapath / unified memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_control_fsm_if;
   logic [6:0] op;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_write;
   logic       adr_src;
   logic       ir_write;
   logic       pc_update;
   logic       reg_write;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] result_src;
   logic       instr_done;
   logic       fault;

   // Control unit side: consumes datapath status, drives control strobes
   modport master (
      input  op, zero, mem_ready,
      output mem_req, mem_write, adr_src, ir_write, pc_update, reg_write,
             alu_src_a, alu_src_b, alu_op, result_src, instr_done, fault
   );

   // Datapath side: supplies status, consumes control strobes
   modport slave (
      output op, zero, mem_ready,
      input  mem_req, mem_write, adr_src, ir_write, pc_update, reg_write,
             alu_src_a, alu_src_b, alu_op, result_src, instr_done, fault
   );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Moore control FSM sequencing the multi-cycle RV32I datapath
//               through fetch/decode/execute/memory/writeback, with a memory
//               ready watchdog and a sticky fault state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
   parameter int unsigned WAIT_TIMEOUT = 15
) (
   input  wire logic                clk,
   input  wire logic                rst,
   multicycle_control_fsm_if.master bus
);

   localparam logic [7:0] c_timeout = 8'(WAIT_TIMEOUT);
   localparam logic [7:0] c_cnt_max = 8'hFF;

   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_rtype  = 7'b0110011;
   localparam logic [6:0] c_op_itype  = 7'b0010011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_jal    = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_FAULT    = 4'd11
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [7:0] r_wait_cnt;

   logic       w_in_wait;
   logic       w_timeout;
   logic       w_pc_write;
   logic       w_branch;

   logic       w_mem_req;
   logic       w_mem_write;
   logic       w_adr_src;
   logic       w_ir_write;
   logic       w_reg_write;
   logic [1:0] w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_alu_op;
   logic [1:0] w_result_src;
   logic       w_instr_done;
   logic       w_fault;

   assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                      (r_state == S_MEMWRITE);
   // The watchdog only fires when the memory is still not ready; a ready on
   // the timeout cycle itself lets the normal transition through.
   assign w_timeout = w_in_wait && !bus.mem_ready && (r_wait_cnt == c_timeout);

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_state_next;
   end

   // Wait counter: cleared on any state change (i.e. on entry to a wait
   // state), counts stalled cycles, saturates so it can never wrap
   always_ff @(posedge clk) begin
      if (rst)
         r_wait_cnt <= 8'd0;
      else if (w_state_next != r_state)
         r_wait_cnt <= 8'd0;
      else if (w_in_wait && !bus.mem_ready && (r_wait_cnt != c_cnt_max))
         r_wait_cnt <= r_wait_cnt + 8'd1;
   end

   // Next-state decode and per-state control outputs
   always_comb begin
      w_state_next = r_state;
      w_mem_req    = 1'b0;
      w_mem_write  = 1'b0;
      w_adr_src    = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_branch     = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_src_a  = 2'b00;
      w_alu_src_b  = 2'b00;
      w_alu_op     = 2'b00;
      w_result_src = 2'b00;
      w_instr_done = 1'b0;
      w_fault      = 1'b0;

      case (r_state)
         S_FETCH: begin
            w_mem_req    = 1'b1;
            w_alu_src_b  = 2'b10;
            w_result_src = 2'b10;
            if (bus.mem_ready) begin
               w_ir_write   = 1'b1;
               w_pc_write   = 1'b1;
               w_state_next = S_DECODE;
            end else if (w_timeout) begin
               w_state_next = S_FAULT;
            end
         end
         S_DECODE: begin
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b01;
            case (bus.op)
               c_op_load, c_op_store: w_state_next = S_MEMADR;
               c_op_rtype:            w_state_next = S_EXECUTER;
               c_op_itype:            w_state_next = S_EXECUTEI;
               c_op_branch:           w_state_next = S_BEQ;
               c_op_jal:              w_state_next = S_JAL;
               default:               w_state_next = S_FAULT;
            endcase
         end
         S_MEMADR: begin
            w_alu_src_a  = 2'b10;
            w_alu_src_b  = 2'b01;
            w_state_next = (bus.op == c_op_load) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            w_mem_req = 1'b1;
            w_adr_src = 1'b1;
            if (bus.mem_ready)  w_state_next = S_MEMWB;
            else if (w_timeout) w_state_next = S_FAULT;
         end
         S_MEMWB: begin
            w_result_src = 2'b01;
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
            w_state_next = S_FETCH;
         end
         S_MEMWRITE: begin
            w_mem_req   = 1'b1;
            w_mem_write = 1'b1;
            w_adr_src   = 1'b1;
            if (bus.mem_ready) begin
               w_instr_done = 1'b1;
               w_state_next = S_FETCH;
            end else if (w_timeout) begin
               w_state_next = S_FAULT;
            end
         end
         S_EXECUTER: begin
            w_alu_src_a  = 2'b10;
            w_alu_op     = 2'b10;
            w_state_next = S_ALUWB;
         end
         S_EXECUTEI: begin
            w_alu_src_a  = 2'b10;
            w_alu_src_b  = 2'b01;
            w_alu_op     = 2'b10;
            w_state_next = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
            w_state_next = S_FETCH;
         end
         S_BEQ: begin
            w_alu_src_a  = 2'b10;
            w_alu_op     = 2'b01;
            w_branch     = 1'b1;
            w_instr_done = 1'b1;
            w_state_next = S_FETCH;
         end
         S_JAL: begin
            // ALU computes oldPC+4 for rd while the PC takes the target
            w_alu_src_a  = 2'b01;
            w_alu_src_b  = 2'b10;
            w_pc_write   = 1'b1;
            w_state_next = S_ALUWB;
         end
         S_FAULT: begin
            w_fault = 1'b1;
         end
         default: begin
            w_state_next = S_FAULT;
         end
      endcase
   end

   assign bus.mem_req    = w_mem_req;
   assign bus.mem_write  = w_mem_write;
   assign bus.adr_src    = w_adr_src;
   assign bus.ir_write   = w_ir_write;
   assign bus.pc_update  = w_pc_write | (w_branch & bus.zero);
   assign bus.reg_write  = w_reg_write;
   assign bus.alu_src_a  = w_alu_src_a;
   assign bus.alu_src_b  = w_alu_src_b;
   assign bus.alu_op     = w_alu_op;
   assign bus.result_src = w_result_src;
   assign bus.instr_done = w_instr_done;
   assign bus.fault      = w_fault;

endmodule

`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit for the multi-cycle RV32I core variant that sequences the shared datapath (PC, IR, ALU, register file, unified memory) through fetch/decode/execute/memory/writeback.
- Moore state machine.
- Handles a memory ready handshake with a watchdog.
- Traps unsupported opcodes into a sticky fault state.

Parameters:
- WAIT_TIMEOUT, 15, maximum consecutive cycles a memory-wait state may hold `mem_req` high without `mem_ready` before entering FAULT; legal range 1..255.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- op  input  7  instr[6:0] from IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory accepted/completed current access this cycle
- mem_req  output  1  memory access request
- mem_write  output  1  store strobe, valid only with `mem_req`
- adr_src  output  1  0 = PC, 1 = ALU result register as memory address
- ir_write  output  1  latch instruction and oldPC
- pc_update  output  1  PC write enable, equal to `pc_write | (branch & zero)`
- reg_write  output  1  register file write enable
- alu_src_a  output  2  00 = PC, 01 = oldPC, 10 = rs1
- alu_src_b  output  2  00 = rs2, 01 = imm, 10 = constant 4
- alu_op  output  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
- result_src  output  2  00 = ALUOut, 01 = memory data, 10 = ALU result
- instr_done  output  1  one-cycle pulse when an instruction retires
- fault  output  1  sticky illegal-opcode / timeout indicator

Behaviour:
- All outputs default to 0 in every state unless listed below.
- Outputs are a function of state only; the exceptions are the `mem_ready`-qualified `ir_write` / `pc_write` / `instr_done` and the `zero`-qualified `pc_update`.
- Reset: `rst` sampled high at a rising edge forces state FETCH and clears the wait counter and `fault`.
  - This holds from any state, including mid memory-wait and FAULT.
  - After reset, outputs are FETCH values.
- Per-state outputs and transitions:
  - FETCH: `mem_req`=1, `adr_src`=0, a=00, b=10, `alu_op`=00, `result_src`=10. When `mem_ready`=1: `ir_write`=1 and `pc_write`=1 in the same cycle, next state DECODE; otherwise stay.
  - DECODE: a=01, b=01, `alu_op`=00 (branch target). Next state by `op`:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other value -> FAULT
  - MEMADR: a=10, b=01, `alu_op`=00. Next state MEMREAD if `op`=0000011, else MEMWRITE.
  - MEMREAD: `mem_req`=1, `adr_src`=1. When `mem_ready`=1, next state MEMWB; otherwise stay.
  - MEMWB: `result_src`=01, `reg_write`=1, `instr_done`=1, next state FETCH.
  - MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1. When `mem_ready`=1: `instr_done`=1, next state FETCH; otherwise stay.
  - EXECUTER: a=10, b=00, `alu_op`=10, next state ALUWB.
  - EXECUTEI: a=10, b=01, `alu_op`=10, next state ALUWB.
  - ALUWB: `result_src`=00, `reg_write`=1, `instr_done`=1, next state FETCH.
  - BEQ: a=10, b=00, `alu_op`=01, `result_src`=00, branch=1 (`pc_update` = `zero`), `instr_done`=1, next state FETCH.
  - JAL: a=01, b=10, `alu_op`=00, `result_src`=00, `pc_write`=1, next state ALUWB (writes rd = oldPC+4).
  - FAULT: `fault`=1, all other outputs 0. Held until `rst`.
- Watchdog (wait states are FETCH, MEMREAD, MEMWRITE):
  - The 8-bit counter clears on entry to a wait state and increments each cycle the state holds with `mem_ready`=0.
  - When the counter equals WAIT_TIMEOUT and `mem_ready`=0, next state is FAULT.
  - If `mem_ready`=1 on that same cycle, `mem_ready` wins and the normal transition is taken.
  - Counter is don't-care outside wait states; it must never wrap.
- Latency with `mem_ready` tied 1:
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
- `instr_done` is exactly one cycle per retired instruction, never asserted in FAULT.

Test Plan:
- Reset with `mem_ready`=1, `op`=0110011 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH. `reg_write` high only in cycle 4, one `instr_done` pulse, `pc_update` only in cycle 1.
- `op`=0000011 with `mem_ready` low for 3 cycles in MEMREAD -> `mem_req`=1, `adr_src`=1 held 4 cycles. MEMWB follows the ready cycle with `result_src`=01. Total 8 cycles.
- `op`=1100011 with `zero`=1, then with `zero`=0 -> `pc_update`=1 in the BEQ cycle only when `zero`=1. `instr_done`=1 in both cases.
- `op`=1111111 -> FAULT after DECODE, `fault`=1 sticky for 20 cycles with all other outputs 0. Pulsing `rst` returns to FETCH with `fault`=0.
- WAIT_TIMEOUT=15, `mem_ready`=0 in FETCH -> FAULT entered on cycle 16. Repeat with `mem_ready`=1 on cycle 16 -> DECODE, no fault.
- `rst` asserted mid-MEMWRITE wait -> next cycle FETCH. `mem_write`=0 immediately after the reset edge, no `instr_done`.
